// File: rtl/mips_multicycle_core_if.sv
// mips_multicycle_core_if
// Instruction and data memory bus of the multi-cycle core.
//   imem_*: fetch request/ack handshake, address = PC, returns instruction word.
//   dmem_*: load/store request/ack handshake with write enable, address, store/load data.
// Modports: master (core side), slave (memory side).
interface mips_multicycle_core_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
// Multi-cycle MIPS-subset core (add/sub/and/or/slt, addi, lw, sw, beq, j). One FSM walks
// BOOT -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and reuses a single ALU.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : mips_multicycle_core_if.master (imem/dmem req/ack handshakes)
//   retired   : count of completed instructions (wraps)
//   halted    : core stopped on an illegal instruction
// Build option: define MC_CORE_ILLEGAL_TRAP_EN to halt on illegal instructions; otherwise
// they execute as NOPs and halted is tied low.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned NREGS_LOG2 = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    mips_multicycle_core_if.master        bus,
    output logic [31:0]                   retired,
    output logic                          halted
);
    localparam int unsigned NRegs = 1 << NREGS_LOG2;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnSub   = 6'b100010;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnSlt   = 6'b101010;

    if (NREGS_LOG2 != 5) begin : g_nregs_check
        $error("NREGS_LOG2 must be 5 for the MIPS encoding");
    end

    typedef enum logic [2:0] {StBoot, StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0] aluout_q, aluout_d, mdr_q, mdr_d, retired_q;
    logic [31:0] rf_q [NRegs];

    logic        retire, rf_we, imem_req, dmem_req;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rtype_result;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic        rtype_ok, illegal;
    logic        unused_shamt;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign unused_shamt = ^ir_q[10:6];

    assign rtype_ok = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                      (funct == FnOr)  || (funct == FnSlt);
    assign illegal  = (op == OpRtype) ? !rtype_ok :
                      !((op == OpAddi) || (op == OpLw) || (op == OpSw) ||
                        (op == OpBeq)  || (op == OpJ));

    always_comb begin
        case (funct)
            FnAdd:   rtype_result = a_q + b_q;
            FnSub:   rtype_result = a_q - b_q;
            FnAnd:   rtype_result = a_q & b_q;
            FnOr:    rtype_result = a_q | b_q;
            FnSlt:   rtype_result = {31'b0, $signed(a_q) < $signed(b_q)};
            default: rtype_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        retire   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d   = rf_q[rs];
                b_d   = rf_q[rt];
                imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
`ifdef MC_CORE_ILLEGAL_TRAP_EN
                state_d = illegal ? StHalt : StExec;
`else
                state_d = StExec;
`endif
            end
            StExec: begin
                if (illegal) begin
                    // Only reachable with the trap disabled: retire as a NOP.
                    retire  = 1'b1;
                    state_d = StFetch;
                end else begin
                    case (op)
                        OpRtype: begin
                            aluout_d = rtype_result;
                            state_d  = StWb;
                        end
                        OpAddi: begin
                            aluout_d = a_q + imm_q;
                            state_d  = StWb;
                        end
                        OpLw, OpSw: begin
                            aluout_d = a_q + imm_q;
                            state_d  = StMem;
                        end
                        OpBeq: begin
                            // pc_q already holds PC+4 here.
                            if (a_q == b_q) pc_d = pc_q + (imm_q << 2);
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                        OpJ: begin
                            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                        default: state_d = StFetch;
                    endcase
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                if (bus.dmem_ack) begin
                    if (op == OpSw) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mdr_d   = bus.dmem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OpRtype) ? rd : rt;
                rf_wdata = (op == OpLw) ? mdr_q : aluout_q;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = state_q;  // StHalt is sticky until reset
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StBoot;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            aluout_q  <= '0;
            mdr_q     <= '0;
            retired_q <= '0;
            for (int i = 0; i < NRegs; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            if (retire) retired_q <= retired_q + 32'd1;
            // Register 0 is never written, so it always reads zero.
            if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = (state_q == StMem) && (op == OpSw);
    assign bus.dmem_addr  = aluout_q;
    assign bus.dmem_wdata = b_q;
    assign retired        = retired_q;

`ifdef MC_CORE_ILLEGAL_TRAP_EN
    assign halted = (state_q == StHalt);
`else
    assign halted = 1'b0;
`endif
endmodule
